// File: rtl/fifo_pkg.sv
// Shared FIFO package: default widths, a ceil-log2 helper and the buffer-index type
// used by both the read-side and write-side adapters.
package fifo_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int BDEPTH_DEF = 2;

  // ceil(log2(v)), never below 1 so it can size a vector directly
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef logic [clog2(BDEPTH_DEF)-1:0] buf_idx_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular skid buffer: push at tail, pop at head, registered head data and count.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int BDEPTH = BDEPTH_DEF,
  parameter int CNTW   = clog2(BDEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic [CNTW-1:0]   count
);

  localparam int            IW   = clog2(BDEPTH);
  localparam logic [IW-1:0] LAST = IW'(BDEPTH - 1);

  logic [BDEPTH-1:0][DWIDTH-1:0] mem;
  logic [IW-1:0]                 wr_idx;
  logic [IW-1:0]                 rd_idx;

  function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  // storage has no reset; head is masked to zero while the buffer is empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

  // index and occupancy bookkeeping; push+pop together leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= idx_next(wr_idx);
      if (pop)  rd_idx <= idx_next(rd_idx);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = (count != '0) ? mem[rd_idx] : '0;

  // credit logic upstream must make overflow and underflow impossible
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && count == CNTW'(BDEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read side to first-word-fall-through valid/ready stream adapter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BDEPTH = BDEPTH_DEF,
  parameter int CWIDTH = 16,
  localparam int CNTW  = clog2(BDEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              fifo_read,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNTW-1:0]   buf_count,
  output logic [CWIDTH-1:0] words_out
);

  localparam int IFW = clog2(RD_LAT + 1);
  localparam int UW  = clog2(BDEPTH + RD_LAT + 1);

  logic [RD_LAT:1] vld_pipe;   // bit k set: a strobe issued k edges ago
  logic [IFW-1:0]  inflight;
  logic [UW-1:0]   used;
  logic            push;
  logic            pop;

  assign out_valid = (buf_count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = vld_pipe[RD_LAT];

  // count of strobes whose data has not yet landed in the buffer
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LAT; i++) inflight = inflight + IFW'(vld_pipe[i]);
  end

  // The slot freed by a pop on this edge is reused immediately; without that the
  // default depth could not sustain one word per clock. out_ready is therefore in
  // the combinational path to fifo_read.
  assign used      = UW'(buf_count) + UW'(inflight) - UW'(pop);
  assign fifo_read = !reset && !fifo_empty && (used < UW'(BDEPTH));

  // return tracking: strobe travels RD_LAT edges, then fifo_q is valid
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= fifo_read;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // delivered-word counter, wraps silently
  always_ff @(posedge rd_clk) begin
    if (reset)    words_out <= '0;
    else if (pop) words_out <= words_out + 1'b1;
  end

  fifo_skid_buf #(
    .DWIDTH (DWIDTH),
    .BDEPTH (BDEPTH),
    .CNTW   (CNTW)
  ) u_buf (
    .clk       (rd_clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_q),
    .pop       (pop),
    .head_data (out_data),
    .count     (buf_count)
  );

endmodule
